// File: rtl/tetris_pkg.sv
// Shared board geometry, coordinate/colour types and painter state encoding
// used by the block painter slice.
package tetris_pkg;

    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int COORD_W    = 7;
    localparam int COLOR_W    = 4;
    localparam int FB_ADDR_W  = 19;

    typedef logic [COORD_W-1:0]   coord_t;
    typedef logic [COLOR_W-1:0]   color_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef enum logic [2:0] {IDLE, SNAP, ERASE, DRAW, FIN} paint_state_t;

    function automatic logic in_board(input coord_t x, input coord_t y);
        return (int'(x) < BOARD_COLS) && (int'(y) < BOARD_ROWS);
    endfunction

endpackage

// File: rtl/block_painter_if.sv
// Framebuffer write port: valid/ready pixel writes toward the RAM arbiter.
interface block_painter_if
    import tetris_pkg::*;
#(
    parameter int ADDR_W = 19
) ();

    logic              fb_we;
    logic              fb_ready;
    logic [ADDR_W-1:0] fb_addr;
    color_t            fb_data;

    modport master (output fb_we, output fb_addr, output fb_data, input fb_ready);
    modport slave  (input fb_we, input fb_addr, input fb_data, output fb_ready);

endinterface

// File: rtl/cell_scanner.sv
// Walks one SQUARE x SQUARE cell row by row, presenting one pixel write at a
// time and advancing only when the framebuffer accepts it.
module cell_scanner
    import tetris_pkg::*;
#(
    parameter int SQUARE   = 16,
    parameter int SCREEN_W = 640,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  color_t            fill,
    input  color_t            border,
    input  logic              fb_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output color_t            fb_data,
    output logic              last
);

    localparam int CW = $clog2(SQUARE);
    localparam logic [CW-1:0] EDGE = CW'(SQUARE - 1);

    logic [CW-1:0] r, c, r_n, c_n;
    color_t        fill_q, border_q;
    logic          accept, row_end;

    always_comb begin
        accept  = fb_we && fb_ready;
        row_end = (c == EDGE);
        last    = accept && row_end && (r == EDGE);
        c_n     = row_end ? '0 : c + CW'(1);
        r_n     = row_end ? r + CW'(1) : r;
    end

    // start takes priority so the next cell follows the last pixel with no gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
            r        <= '0;
            c        <= '0;
            fill_q   <= '0;
            border_q <= '0;
        end else if (start) begin
            fb_we    <= 1'b1;
            fb_addr  <= base;
            fb_data  <= border;
            r        <= '0;
            c        <= '0;
            fill_q   <= fill;
            border_q <= border;
        end else if (accept) begin
            if (last) begin
                fb_we <= 1'b0;
            end else begin
                r       <= r_n;
                c       <= c_n;
                fb_addr <= row_end ? fb_addr + ADDR_W'(SCREEN_W - SQUARE + 1)
                                   : fb_addr + ADDR_W'(1);
                fb_data <= (r_n == '0 || r_n == EDGE || c_n == '0 || c_n == EDGE)
                           ? border_q : fill_q;
            end
        end
    end

endmodule

// File: rtl/block_painter.sv
// Erases the previous piece and paints the current one into the framebuffer.
// Define BLOCK_PAINTER_OUTLINE_EN to draw cell borders in the inverted colour.
module block_painter
    import tetris_pkg::*;
#(
    parameter int SQUARE   = 16,
    parameter int SCREEN_W = 640,
    parameter int BOARD_X0 = 240,
    parameter int BOARD_Y0 = 80,
    parameter int ADDR_W   = 19,
    parameter int BG_COLOR = 0
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            update,
    input  coord_t [3:0]    blockXPos,
    input  coord_t [3:0]    blockYPos,
    input  coord_t [3:0]    blockXPrev,
    input  coord_t [3:0]    blockYPrev,
    input  color_t          blockColor,
    block_painter_if.master fb,
    output logic            busy,
    output logic            done
);

    paint_state_t      state;
    logic [2:0]        slot;
    logic [7:0]        skip_q, skip_live, pending;
    coord_t [7:0]      x_q, y_q, x_live, y_live;
    color_t            color_q, ccol, fill, border;
    logic              snap, has_next, start, scan_last;
    logic [2:0]        nxt;
    int unsigned       from;
    logic [ADDR_W-1:0] base;

    function automatic logic [ADDR_W-1:0] cell_base(input coord_t x, input coord_t y);
        return ADDR_W'(BOARD_Y0 + int'(y) * SQUARE) * ADDR_W'(SCREEN_W)
             + ADDR_W'(BOARD_X0 + int'(x) * SQUARE);
    endfunction

    // Slots 0..3 are the previous cells (erase), 4..7 the current cells (draw)
    always_comb begin
        skip_live = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            x_live[i]        = blockXPrev[i];
            y_live[i]        = blockYPrev[i];
            x_live[i+4]      = blockXPos[i];
            y_live[i+4]      = blockYPos[i];
            skip_live[i+4]   = !in_board(blockXPos[i], blockYPos[i]);
            skip_live[i]     = !in_board(blockXPrev[i], blockYPrev[i]);
            for (int unsigned j = 0; j < 4; j++) begin
                if (blockXPrev[i] == blockXPos[j] && blockYPrev[i] == blockYPos[j])
                    skip_live[i] = 1'b1;
            end
        end
    end

    // In SNAP the first cell is chosen from live inputs so scanning starts at once
    always_comb begin
        snap     = (state == SNAP);
        pending  = snap ? ~skip_live : ~skip_q;
        from     = snap ? 0 : int'(slot) + 1;
        has_next = 1'b0;
        nxt      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!has_next && i >= from && pending[i]) begin
                has_next = 1'b1;
                nxt      = 3'(i);
            end
        end
        base = snap ? cell_base(x_live[nxt], y_live[nxt]) : cell_base(x_q[nxt], y_q[nxt]);
        ccol = snap ? blockColor : color_q;
        fill = nxt[2] ? ccol : color_t'(BG_COLOR);
`ifdef BLOCK_PAINTER_OUTLINE_EN
        border = nxt[2] ? ~ccol : color_t'(BG_COLOR);
`else
        border = fill;
`endif
        start = has_next && (snap || scan_last);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            slot    <= '0;
            skip_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (update) begin
                        state <= SNAP;
                        busy  <= 1'b1;
                    end
                end
                SNAP: begin
                    x_q     <= x_live;
                    y_q     <= y_live;
                    skip_q  <= skip_live;
                    color_q <= blockColor;
                    if (has_next) begin
                        slot  <= nxt;
                        state <= nxt[2] ? DRAW : ERASE;
                    end else begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ERASE, DRAW: begin
                    if (scan_last) begin
                        if (has_next) begin
                            slot  <= nxt;
                            state <= nxt[2] ? DRAW : ERASE;
                        end else begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    cell_scanner #(
        .SQUARE  (SQUARE),
        .SCREEN_W(SCREEN_W),
        .ADDR_W  (ADDR_W)
    ) u_scanner (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .start   (start),
        .base    (base),
        .fill    (fill),
        .border  (border),
        .fb_ready(fb.fb_ready),
        .fb_we   (fb.fb_we),
        .fb_addr (fb.fb_addr),
        .fb_data (fb.fb_data),
        .last    (scan_last)
    );

endmodule

// File: tb/tb_block_painter.sv
// Self-checking bench for block_painter: directed cases plus randomized
// piece updates compared against a pixel-list reference model.
module tb_block_painter;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             update;
    logic [3:0][6:0]  xpos, ypos, xprev, yprev;
    logic [3:0]       color;
    logic             busy, done;

    block_painter_if #(.ADDR_W(19)) fb ();

    block_painter #(
        .SQUARE(16), .SCREEN_W(640), .BOARD_X0(240), .BOARD_Y0(80), .ADDR_W(19), .BG_COLOR(0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .update(update),
        .blockXPos(xpos), .blockYPos(ypos), .blockXPrev(xprev), .blockYPrev(yprev),
        .blockColor(color), .fb(fb), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    typedef struct { int unsigned addr; int unsigned data; } wr_t;
    wr_t expq[$];
    wr_t got[$];

    int unsigned px[4], py[4], cx[4], cy[4], col;
    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    int unsigned tick = 0;
    logic        hold_pending = 1'b0;
    logic [18:0] hold_addr;
    logic [3:0]  hold_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: list every pixel write the update should produce, in order
    task automatic build_model();
        bit skip;
        expq.delete();
        for (int i = 0; i < 4; i++) begin
            skip = !(px[i] < 10 && py[i] < 20);
            for (int j = 0; j < 4; j++)
                if (px[i] == cx[j] && py[i] == cy[j]) skip = 1;
            if (!skip)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++)
                        expq.push_back('{(80 + py[i]*16 + r)*640 + 240 + px[i]*16 + c, 0});
        end
        for (int i = 0; i < 4; i++) begin
            if (cx[i] < 10 && cy[i] < 20)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++) begin
                        int unsigned d = col;
`ifdef BLOCK_PAINTER_OUTLINE_EN
                        if (r == 0 || r == 15 || c == 0 || c == 15) d = (~col) & 15;
`endif
                        expq.push_back('{(80 + cy[i]*16 + r)*640 + 240 + cx[i]*16 + c, d});
                    end
        end
    endtask

    initial begin
        fb.fb_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            tick++;
            case (rdy_mode)
                0: fb.fb_ready = 1'b1;
                1: fb.fb_ready = (tick % 4 == 0) || (tick % 4 == 3);
                default: fb.fb_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Collect accepted writes and check that a stalled request stays put
    always @(negedge Clk) begin
        if (!Reset_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_we", 32'(fb.fb_we), 32'd1);
                chk("hold_addr", 32'(fb.fb_addr), 32'(hold_addr));
                chk("hold_data", 32'(fb.fb_data), 32'(hold_data));
            end
            hold_pending = 1'b0;
            if (fb.fb_we === 1'b1) begin
                if (fb.fb_ready === 1'b1) begin
                    got.push_back('{int'(fb.fb_addr), int'(fb.fb_data)});
                end else begin
                    hold_pending = 1'b1;
                    hold_addr    = fb.fb_addr;
                    hold_data    = fb.fb_data;
                end
            end
        end
    end

    task automatic set_drop_by_one();
        px = '{4, 5, 5, 6}; py = '{0, 0, 1, 1};
        cx = '{4, 5, 5, 6}; cy = '{1, 1, 2, 2};
        col = 3;
    endtask

    task automatic run(input string tag, input bit check_lat, input bit poke);
        int cyc;
        bit seen;
        int bad;
        build_model();
        got.delete();
        @(posedge Clk); #1;
        for (int i = 0; i < 4; i++) begin
            xprev[i] = 7'(px[i]); yprev[i] = 7'(py[i]);
            xpos[i]  = 7'(cx[i]); ypos[i]  = 7'(cy[i]);
        end
        color  = 4'(col);
        update = 1'b1;
        @(negedge Clk);
        cyc  = 0;
        seen = 0;
        while (cyc < 20000 && !seen) begin
            @(posedge Clk); #1;
            update = poke && (cyc == 300);
            if (poke && cyc == 300) begin
                xpos[0] = 7'($urandom_range(0, 9));
                color   = 4'($urandom_range(0, 15));
            end
            @(negedge Clk);
            cyc++;
            if (cyc == 1) chk({tag, "_busy_snap"}, 32'(busy), 32'd1);
            if (done === 1'b1) seen = 1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        if (check_lat) chk({tag, "_latency"}, 32'(cyc), 32'(2 + expq.size()));
        @(negedge Clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        repeat (20) @(negedge Clk);
        chk({tag, "_write_count"}, 32'(got.size()), 32'(expq.size()));
        bad = -1;
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            if (bad < 0 && (got[i].addr != expq[i].addr || got[i].data != expq[i].data)) bad = i;
        chk({tag, "_first_bad_write"}, 32'(bad), 32'hFFFF_FFFF);
    endtask

    initial begin
        int n12, n3;
        Reset_n = 1'b0;
        update  = 1'b0;
        xpos = '0; ypos = '0; xprev = '0; yprev = '0; color = '0;
        repeat (3) @(negedge Clk);
        chk("rst_we", 32'(fb.fb_we), 32'd0);
        chk("rst_addr", 32'(fb.fb_addr), 32'd0);
        chk("rst_data", 32'(fb.fb_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // drop by one, full ready
        rdy_mode = 0;
        set_drop_by_one();
        run("drop", 1, 0);
        chk("drop_count_exp", 32'(got.size()), 32'd1792);
        if (got.size() > 768) begin
            chk("drop_first_erase", got[0].addr, 32'd51504);
            chk("drop_erase_data", got[0].data, 32'd0);
            chk("drop_first_draw", got[768].addr, 32'd61744);
`ifdef BLOCK_PAINTER_OUTLINE_EN
            chk("drop_draw_data", got[768].data, 32'd12);
`else
            chk("drop_draw_data", got[768].data, 32'd3);
`endif
        end else chk("drop_size_short", 32'(got.size()), 32'd1792);

        // full skip: overlap on erase, out of range on draw
        px = '{4, 5, 5, 6}; py = '{0, 0, 1, 1};
        cx = '{10, 10, 10, 10}; cy = '{0, 0, 1, 1};
        px = '{10, 10, 10, 10};
        col = 5;
        run("skip", 1, 0);
        chk("skip_no_writes", 32'(got.size()), 32'd0);

        // single cell address range and outline split
        px = '{10, 10, 10, 10}; py = '{0, 0, 0, 0};
        cx = '{1, 10, 10, 10}; cy = '{2, 0, 0, 0};
        col = 3;
        run("cell", 1, 0);
        if (got.size() == 256) begin
            chk("cell_first_addr", got[0].addr, 32'd71936);
            chk("cell_last_addr", got[255].addr, 32'd81551);
            n12 = 0; n3 = 0;
            foreach (got[i]) begin
                if (got[i].data == 12) n12++;
                if (got[i].data == 3) n3++;
            end
`ifdef BLOCK_PAINTER_OUTLINE_EN
            chk("cell_border_cnt", 32'(n12), 32'd60);
            chk("cell_inner_cnt", 32'(n3), 32'd196);
`else
            chk("cell_border_cnt", 32'(n12), 32'd0);
            chk("cell_inner_cnt", 32'(n3), 32'd256);
`endif
        end else chk("cell_size", 32'(got.size()), 32'd256);

        // backpressure 1,0,0,1 with an ignored update mid-run
        rdy_mode = 1;
        set_drop_by_one();
        run("bp", 0, 1);
        rdy_mode = 0;

        // randomized updates under random ready
        rdy_mode = 2;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++) begin
                cx[i] = $urandom_range(0, 11);
                cy[i] = $urandom_range(0, 21);
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    int j = $urandom_range(0, 3);
                    px[i] = cx[j]; py[i] = cy[j];
                end else begin
                    px[i] = $urandom_range(0, 11);
                    py[i] = $urandom_range(0, 21);
                end
            end
            col = $urandom_range(0, 15);
            run($sformatf("rand%0d", t), 0, 0);
        end
        rdy_mode = 0;

        // reset mid-scan abandons the update
        set_drop_by_one();
        @(posedge Clk); #1;
        for (int i = 0; i < 4; i++) begin
            xprev[i] = 7'(px[i]); yprev[i] = 7'(py[i]);
            xpos[i]  = 7'(cx[i]); ypos[i]  = 7'(cy[i]);
        end
        color  = 4'(col);
        update = 1'b1;
        @(posedge Clk); #1;
        update = 1'b0;
        repeat (100) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("midrst_we", 32'(fb.fb_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        got.delete();
        repeat (50) @(negedge Clk);
        chk("postrst_writes", 32'(got.size()), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_painter.md
Name: block_painter

Overview:
- Consumer of the game-logic piece outputs: current and previous positions of the 4 blocks, plus the colour index.
- On each update strobe it snapshots those inputs. It then erases the previous squares to background and paints the current squares into the pixel framebuffer.
- Writes go through a valid/ready write port shared with the VGA-side arbiter.
- Sits between the game-logic block and framebuffer RAM.

Parameters:
- SQUARE, 16, pixels per cell edge (power of 2).
- SCREEN_W, 640, framebuffer row pitch in pixels.
- BOARD_X0, 240, pixel X of board cell (0,0).
- BOARD_Y0, 80, pixel Y of board cell (0,0).
- ADDR_W, 19, framebuffer address width.
- BG_COLOR, 0, palette index written on erase.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- update  in  1  single-cycle start strobe, synchronous to Clk.
- blockXPos  in  7 x4  current block columns.
- blockYPos  in  7 x4  current block rows.
- blockXPrev  in  7 x4  previous block columns.
- blockYPrev  in  7 x4  previous block rows.
- blockColor  in  4  palette index for current blocks.
- fb_we  out  1  write request (valid).
- fb_ready  in  1  framebuffer accepts the write this cycle.
- fb_addr  out  ADDR_W  pixel address.
- fb_data  out  4  palette index.
- busy  out  1  high from snapshot until done.
- done  out  1  single-cycle pulse at end of update.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0; counters cleared. Reset mid-update abandons the update immediately; no further writes.
- States and transitions:
  - IDLE --update--> SNAP.
  - SNAP (1 cycle): latch all positions and colour; compute skip masks; busy=1.
  - SNAP --> ERASE, or DRAW if every erase cell is skipped, or FIN if every cell in both phases is skipped.
  - ERASE: cells 0..3 in order --> DRAW.
  - DRAW: cells 0..3 in order --> FIN.
  - FIN (1 cycle): done=1, busy=0 --> IDLE.
- update while busy is ignored and not queued. Inputs are sampled only in SNAP.
- Erase skip: prev cell i is skipped if it equals any current cell (X and Y both match). This avoids flicker on overlap.
- Range skip: any cell with X>BOARD_COLS-1 or Y>BOARD_ROWS-1 is skipped in either phase.
- Per non-skipped cell:
  - Scan rows r=0..SQUARE-1, and within each row columns c=0..SQUARE-1.
  - fb_addr = (BOARD_Y0 + Y*SQUARE + r)*SCREEN_W + BOARD_X0 + X*SQUARE + c, computed at ADDR_W width. Parameters guarantee no overflow.
  - fb_data = BG_COLOR in ERASE, latched colour in DRAW.
- Handshake:
  - fb_we held high with fb_addr/fb_data stable until a cycle with fb_ready=1.
  - The counter advances only on fb_we && fb_ready.
  - A new request may be presented in the cycle after acceptance (back-to-back, 1 pixel/cycle at full ready).
  - fb_we=0 in IDLE, SNAP, FIN, and on skipped cells. Skipped cells cost 0 cycles.
- Latency at fb_ready=1: 1 (SNAP) + N*SQUARE² + 1 (FIN) cycles from update to done. N = number of non-skipped cells, max 8.

Optional Feature:
- BLOCK_PAINTER_OUTLINE_EN defined:
  - In DRAW, pixels with r or c equal to 0 or SQUARE-1 are written with fb_data = ~latched colour (4-bit invert).
  - Interior pixels use the latched colour.
- Undefined: whole cell uses latched colour.
- ERASE is unaffected in both cases; write count is unaffected in both cases.

Decomposition:
- Package tetris_pkg holds:
  - BOARD_COLS=10, BOARD_ROWS=20, COORD_W=7, COLOR_W=4.
  - typedef coord_t (logic [COORD_W-1:0]), color_t, fb_addr_t.
  - Enum paint_state_t {IDLE,SNAP,ERASE,DRAW,FIN}.
- One sub-module, cell_scanner:
  - Takes cell base address and a start pulse.
  - Runs the r/c counters and the valid/ready handshake.
  - Returns a last-pixel-accepted pulse.
- The parent holds the FSM, snapshot, skip masks and base-address math.

Test Plan:
- Reset: hold Reset_n=0 mid-scan -> fb_we=0, busy=0, done=0 the same cycle. After release, no writes until next update.
- Identical sets: prev = cur = {(4,0),(5,0),(5,1),(6,1)} but cur cells forced out-of-range on draw... (see next).
- Full skip: every prev cell matches a cur cell and every cur cell is out of range (X=10) -> zero fb_we cycles; done exactly 2 cycles after update.
- Drop by one: prev {(4,0),(5,0),(5,1),(6,1)}, cur {(4,1),(5,1),(5,2),(6,2)}, colour 3, fb_ready=1 ->
  - 768 writes of 0, then 1024 writes of 3; done at cycle 1794.
  - First erase address 51440 (cell (4,0) -> 51440+64 = 51504 for X offset; cell (0,0) base is 51440).
  - First draw of (4,1) is at 51504+16*640 = 61744.
- Address check: single cell (1,2) -> first address 71936, last address 71936+15*640+15 = 81551.
- Backpressure: fb_ready toggles 1,0,0,1 repeatedly -> each address held stable while ready=0. Write count is still 256 per cell, with no duplicated or dropped address. update pulsed mid-run is ignored.
- Outline (macro on): colour 3 cell -> 60 border writes of 12 and 196 interior writes of 3.
